// File: rtl/button_debounce_wb.sv
// Wishbone pushbutton front end: two-flop synchroniser, debounce, press counter, sticky flag, LEDs, irq.
// Latency: pin to stable is 2+thr cycles; bus ack and read data are registered, one cycle after request.
// Backpressure: none; every in-window request is acked next cycle, and back-to-back strobes are acked on alternate cycles.
module button_debounce_wb #(
    parameter logic [31:0] BASE_ADDR       = 32'h3000_0000,
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic [4:0]  io_in,
    output logic [4:0]  io_out,
    output logic [4:0]  io_oeb,
    output logic [2:0]  irq
);

    logic        sync_a;
    logic        sync_b;
    logic        stable;
    logic [15:0] cnt;
    logic [15:0] count;
    logic        pending;
    logic [5:0]  ctrl;
    logic [15:0] debounce;

    logic [15:0] thr;
    logic [15:0] thr_m1;
    logic        differ;
    logic        flip;
    logic        press;
    logic        hit;
    logic        req;
    logic        wr;
    logic [1:0]  idx;
    logic [31:0] rdata;

    // A threshold of zero behaves like one so the filter never stalls.
    assign thr    = (debounce == 16'd0) ? 16'd1 : debounce;
    assign thr_m1 = thr - 16'd1;
    assign differ = (sync_b != stable);
    assign flip   = differ && (cnt == thr_m1);
    assign press  = flip && sync_b;

    assign hit = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req = wbs_cyc_i && wbs_stb_i && hit && !wbs_ack_o;
    assign wr  = req && wbs_we_i;
    assign idx = wbs_adr_i[3:2];

    // Read mux for the register selected by the current request.
    always_comb begin
        rdata = 32'd0;
        case (idx)
            2'd0:    rdata = {30'd0, pending, stable};
            2'd1:    rdata = {16'd0, count};
            2'd2:    rdata = {26'd0, ctrl};
            default: rdata = {16'd0, debounce};
        endcase
    end

    // Two-flop synchroniser on the asynchronous button pin.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= io_in[3];
            sync_b <= sync_a;
        end
    end

    // Debounce: stable follows sync after thr consecutive differing cycles.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            stable <= 1'b0;
            cnt    <= 16'd0;
        end else if (!differ) begin
            cnt <= 16'd0;
        end else if (flip) begin
            stable <= sync_b;
            cnt    <= 16'd0;
        end else begin
            cnt <= cnt + 16'd1;
        end
    end

    // Press flag and counter; a press on the same edge as a clear wins.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            pending <= 1'b0;
            count   <= 16'd0;
        end else begin
            if (press) begin
                pending <= 1'b1;
            end else if (wr && idx == 2'd0 && wbs_sel_i[0] && wbs_dat_i[1]) begin
                pending <= 1'b0;
            end
            if (wr && idx == 2'd1 && wbs_sel_i[0]) begin
                count <= press ? 16'd1 : 16'd0;
            end else if (press) begin
                count <= count + 16'd1;
            end
        end
    end

    // Software-owned control and threshold registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ctrl     <= 6'd0;
            debounce <= DEBOUNCE_CYCLES;
        end else if (wr) begin
            if (idx == 2'd2 && wbs_sel_i[0]) begin
                ctrl <= wbs_dat_i[5:0];
            end
            if (idx == 2'd3) begin
                if (wbs_sel_i[0]) debounce[7:0]  <= wbs_dat_i[7:0];
                if (wbs_sel_i[1]) debounce[15:8] <= wbs_dat_i[15:8];
            end
        end
    end

    // Single-cycle registered ack; read data is only non-zero alongside ack.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'd0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= req ? rdata : 32'd0;
        end
    end

    assign io_out = {2'b00, ctrl[1] ? ctrl[5:3] : {3{stable}}};
    assign io_oeb = 5'b11000;
    assign irq    = {2'b00, pending & ctrl[0]};

    logic unused_bits;
    assign unused_bits = ^{io_in[4], io_in[2:0], wbs_adr_i[1:0], wbs_dat_i[31:16], wbs_sel_i[3:2]};

endmodule

// File: tb/tb_button_debounce_wb.sv
// Bench for button_debounce_wb: register table, hand-timed corner sequences,
// and randomized pin activity compared against a sliding-window debounce model.
module tb_button_debounce_wb;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic        ack;
    logic [31:0] rdat;
    logic [4:0]  io_in, io_out, io_oeb;
    logic [2:0]  irq;

    int total = 0;
    int bad   = 0;

    button_debounce_wb #(.BASE_ADDR(BASE), .DEBOUNCE_CYCLES(16'd4)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_dat_i(wdat), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Other io_in bits carry junk to show they are ignored.
    task automatic set_pin(input logic p);
        io_in = {1'b1, p, 3'b101};
    endtask

    task automatic access(input logic [31:0] a, input logic w, input logic [3:0] s,
                          input logic [31:0] d, output logic got, output logic [31:0] rd);
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        got = 1'b0; rd = 32'd0;
        for (int i = 0; i < 4 && !got; i++) begin
            tick();
            if (ack) begin
                got = 1'b1;
                rd  = rdat;
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; wdat = 32'd0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        logic g;
        logic [31:0] r;
        access(a, 1'b1, s, d, g, r);
        check("wr_ack", 32'(g), 32'd1);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic g;
        logic [31:0] r;
        access(a, 1'b0, 4'hF, 32'd0, g, r);
        check("rd_ack", 32'(g), 32'd1);
        check(name, r, exp);
    endtask

    // Reference: sync seen at edge k is the pin sampled two edges earlier;
    // stable flips once the last thr sync samples all disagree with it.
    task automatic run_random(input int thr_reg, input int ncyc);
        logic pins[$];
        logic mstable = 1'b0;
        logic p = 1'b0;
        logic all_diff, s;
        int   thr, hold, rises, idx;
        thr   = (thr_reg == 0) ? 1 : thr_reg;
        hold  = 0;
        rises = 0;
        wr(BASE + 32'hC, 4'h3, 32'(thr_reg));
        wr(BASE + 32'h4, 4'h1, 32'd0);
        wr(BASE + 32'h0, 4'h1, 32'd2);
        for (int k = 0; k < ncyc; k++) begin
            if (k >= ncyc - 12) begin
                p = 1'b0;
            end else if (hold == 0) begin
                p    = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 2 * thr + 1);
            end
            if (hold > 0) hold--;
            set_pin(p);
            tick();
            pins.push_back(p);
            all_diff = 1'b1;
            for (int j = 0; j < thr; j++) begin
                idx = k - 2 - j;
                s   = (idx >= 0) ? pins[idx] : 1'b0;
                if (s == mstable) all_diff = 1'b0;
            end
            if (all_diff) begin
                mstable = ~mstable;
                if (mstable) rises++;
            end
            check("rnd_led", 32'(io_out[2:0]), 32'({3{mstable}}));
        end
        rd_chk("rnd_count", BASE + 32'h4, 32'(rises));
        rd_chk("rnd_status", BASE + 32'h0, {30'd0, (rises > 0), 1'b0});
    endtask

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] wdat;
        logic        exp_ack;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [0:18];

    initial begin
        logic        g;
        logic [31:0] r;

        tbl[0]  = '{BASE + 32'h0,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[1]  = '{BASE + 32'h4,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[2]  = '{BASE + 32'h8,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[3]  = '{BASE + 32'hC,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h4};
        tbl[4]  = '{BASE + 32'h8,  1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        tbl[5]  = '{BASE + 32'h8,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h3F};
        tbl[6]  = '{BASE + 32'h8,  1'b1, 4'hE, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[7]  = '{BASE + 32'h8,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h3F};
        tbl[8]  = '{BASE + 32'hC,  1'b1, 4'h1, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        tbl[9]  = '{BASE + 32'hC,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h78};
        tbl[10] = '{BASE + 32'hC,  1'b1, 4'h2, 32'h0000_AB00, 1'b1, 1'b0, 32'h0};
        tbl[11] = '{BASE + 32'hC,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'hAB78};
        tbl[12] = '{BASE + 32'hC,  1'b1, 4'hF, 32'hFFFF_0004, 1'b1, 1'b0, 32'h0};
        tbl[13] = '{BASE + 32'hC,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h4};
        tbl[14] = '{BASE + 32'h10, 1'b0, 4'hF, 32'h0,         1'b0, 1'b0, 32'h0};
        tbl[15] = '{BASE + 32'h14, 1'b1, 4'hF, 32'h0,         1'b0, 1'b0, 32'h0};
        tbl[16] = '{BASE + 32'h8,  1'b1, 4'h1, 32'h0,         1'b1, 1'b0, 32'h0};
        tbl[17] = '{BASE + 32'h8,  1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
        tbl[18] = '{BASE + 32'h0,  1'b1, 4'h1, 32'h2,         1'b1, 1'b0, 32'h0};

        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        wdat = 32'd0; adr = 32'd0;
        set_pin(1'b0);
        repeat (3) tick();
        rst = 1'b0;

        // Reset state and static outputs.
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_io_out", 32'(io_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("io_oeb", 32'(io_oeb), 32'h18);

        // Ack one cycle after strobe; held strobe is acked on alternate cycles.
        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = BASE + 32'hC;
        check("ack_before_edge", 32'(ack), 32'd0);
        tick();
        check("ack_first", 32'(ack), 32'd1);
        check("dat_first", rdat, 32'd4);
        tick();
        check("ack_gap", 32'(ack), 32'd0);
        check("dat_gap", rdat, 32'd0);
        tick();
        check("ack_second", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0;
        tick();
        check("ack_idle", 32'(ack), 32'd0);

        // Register table.
        for (int i = 0; i < 19; i++) begin
            access(tbl[i].adr, tbl[i].we, tbl[i].sel, tbl[i].wdat, g, r);
            check($sformatf("tbl%0d_ack", i), 32'(g), 32'(tbl[i].exp_ack));
            if (tbl[i].chk_rd) check($sformatf("tbl%0d_dat", i), r, tbl[i].exp_rd);
        end
        tick();

        // Held press with thr=4: stable rises on the sixth edge after the pin.
        set_pin(1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_early", 32'(io_out[2:0]), 32'd0);
        end
        tick();
        check("hold_rise", 32'(io_out[2:0]), 32'h7);
        rd_chk("hold_count", BASE + 32'h4, 32'd1);
        rd_chk("hold_status", BASE + 32'h0, 32'd3);
        set_pin(1'b0);
        repeat (8) tick();
        check("hold_release", 32'(io_out[2:0]), 32'd0);

        // Short glitch is filtered out.
        wr(BASE + 32'h4, 4'h1, 32'd0);
        wr(BASE + 32'h0, 4'h1, 32'd2);
        set_pin(1'b1);
        repeat (3) tick();
        set_pin(1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("glitch_led", 32'(io_out[2:0]), 32'd0);
        end
        rd_chk("glitch_count", BASE + 32'h4, 32'd0);
        rd_chk("glitch_status", BASE + 32'h0, 32'd0);

        // Interrupt raise and W1C clear.
        wr(BASE + 32'h8, 4'h1, 32'h1);
        check("irq_idle", 32'(irq), 32'd0);
        set_pin(1'b1);
        repeat (6) tick();
        check("irq_set", 32'(irq), 32'd1);
        wr(BASE + 32'h0, 4'h1, 32'h2);
        check("irq_cleared", 32'(irq), 32'd0);
        set_pin(1'b0);
        repeat (8) tick();

        // W1C on the same edge as a press: press wins.
        set_pin(1'b1);
        repeat (5) tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h1; adr = BASE + 32'h0; wdat = 32'h2;
        tick();
        check("same_w1c_ack", 32'(ack), 32'd1);
        check("same_w1c_led", 32'(io_out[2:0]), 32'h7);
        check("same_w1c_irq", 32'(irq), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        rd_chk("same_w1c_status", BASE + 32'h0, 32'd3);

        // COUNT clear on the same edge as a press gives one.
        wr(BASE + 32'h4, 4'h1, 32'd0);
        set_pin(1'b0);
        repeat (8) tick();
        set_pin(1'b1);
        repeat (5) tick();
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'h1; adr = BASE + 32'h4; wdat = 32'h0;
        tick();
        check("same_cnt_ack", 32'(ack), 32'd1);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        tick();
        rd_chk("same_cnt_count", BASE + 32'h4, 32'd1);
        set_pin(1'b0);
        repeat (8) tick();

        // Fast toggling with thr=1: one press per two cycles.
        wr(BASE + 32'h8, 4'h1, 32'h0);
        wr(BASE + 32'hC, 4'h3, 32'd1);
        wr(BASE + 32'h4, 4'h1, 32'd0);
        for (int i = 0; i < 600; i++) begin
            set_pin((i % 2) == 0);
            tick();
        end
        set_pin(1'b0);
        repeat (6) tick();
        rd_chk("toggle_count", BASE + 32'h4, 32'd300);

        // Randomized activity against the window model, including thr=0.
        run_random(3, 400);
        run_random(0, 300);
        run_random(2, 300);

        // Software LED mode ignores the button.
        wr(BASE + 32'h8, 4'h1, 32'h2A);
        check("led_sw_idle", 32'(io_out), 32'h5);
        set_pin(1'b1);
        repeat (10) tick();
        check("led_sw_pressed", 32'(io_out), 32'h5);
        check("irq_upper", 32'(irq[2:1]), 32'd0);
        set_pin(1'b0);
        repeat (10) tick();
        check("led_sw_released", 32'(io_out), 32'h5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
